// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: walks a low level across the columns, samples the
// rows through a two-flop synchroniser, debounces press and release on the
// scan tick, and packs each accepted key into a 32-bit display-order word.
module keypad_scan #(
    parameter int SCAN_DIV       = 150000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    input  logic        clear,
    output logic [3:0]  key_col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [31:0] data,
    output logic [2:0]  digit_cnt,
    output logic        word_valid
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DBNC_LAST = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DBNC_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t          state_reg;
    logic [3:0]      row_meta_reg;
    logic [3:0]      row_s_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic [3:0]      key_col_reg;
    logic [3:0]      cand_reg;
    logic [DW-1:0]   dcnt_reg;
    logic [3:0]      key_code_reg;
    logic            key_valid_reg;
    logic [31:0]     data_reg;
    logic [2:0]      digit_cnt_reg;
    logic            word_valid_reg;

    logic            tick;
    logic [3:0]      row_hit;
    logic [3:0]      col_hit;
    logic            row_valid;
    logic            rows_idle;
    logic [1:0]      row_idx;
    logic [1:0]      col_idx;
    logic [3:0]      code;
    logic [DW-1:0]   dcnt_inc;
    logic            accept;

    // Two-flop synchroniser for the asynchronous, pulled-up row lines
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_reg <= 4'hF;
            row_s_reg    <= 4'hF;
        end else begin
            row_meta_reg <= key_row;
            row_s_reg    <= row_meta_reg;
        end
    end

    // Free-running scan tick divider, independent of the scan state
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    assign tick = (tick_cnt_reg == TICK_LAST);

    // One-hot match of rows and column against the single-low patterns
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            localparam logic [3:0] PAT = ~(4'b0001 << gi);
            assign row_hit[gi] = (row_s_reg == PAT);
            assign col_hit[gi] = (key_col_reg == PAT);
        end
    endgenerate

    // Anything other than exactly one low row (idle or ghosting) is not a key
    assign row_valid = |row_hit;
    assign rows_idle = (row_s_reg == 4'hF);
    assign row_idx   = {row_hit[3] | row_hit[2], row_hit[3] | row_hit[1]};
    assign col_idx   = {col_hit[3] | col_hit[2], col_hit[3] | col_hit[1]};
    assign code      = {row_idx, col_idx};
    assign dcnt_inc  = dcnt_reg + DBNC_ONE;

    // Accept decision shared by the FSM and the digit-assembly path
    always_comb begin
        accept = 1'b0;
        if (tick) begin
            case (state_reg)
                ST_SCAN:     accept = row_valid && (DEBOUNCE_SCANS == 1);
                ST_DEBOUNCE: accept = (row_s_reg == cand_reg) && (dcnt_inc == DBNC_LAST);
                default:     accept = 1'b0;
            endcase
        end
    end

    // Scan/debounce state machine; every transition waits for a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_SCAN;
            key_col_reg <= 4'b1110;
            cand_reg    <= 4'hF;
            dcnt_reg    <= '0;
        end else if (tick) begin
            case (state_reg)
                ST_SCAN: begin
                    if (row_valid) begin
                        // Freeze the column on this key and start counting
                        cand_reg  <= row_s_reg;
                        dcnt_reg  <= DBNC_ONE;
                        state_reg <= accept ? ST_HELD : ST_DEBOUNCE;
                    end else begin
                        key_col_reg <= {key_col_reg[2:0], key_col_reg[3]};
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s_reg == cand_reg) begin
                        dcnt_reg <= dcnt_inc;
                        if (accept) begin
                            state_reg <= ST_HELD;
                        end
                    end else begin
                        // Bounce or glitch: drop the candidate and move on
                        state_reg   <= ST_SCAN;
                        key_col_reg <= {key_col_reg[2:0], key_col_reg[3]};
                    end
                end
                ST_HELD: begin
                    if (rows_idle) begin
                        dcnt_reg  <= DBNC_ONE;
                        state_reg <= (DEBOUNCE_SCANS == 1) ? ST_SCAN : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (rows_idle) begin
                        dcnt_reg <= dcnt_inc;
                        if (dcnt_inc == DBNC_LAST) begin
                            state_reg <= ST_SCAN;
                        end
                    end else begin
                        state_reg <= ST_HELD;
                    end
                end
                default: begin
                    state_reg <= ST_SCAN;
                end
            endcase
        end
    end

    // Registered key report and word assembly; clear wins over the shift
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code_reg   <= 4'h0;
            key_valid_reg  <= 1'b0;
            data_reg       <= 32'h0;
            digit_cnt_reg  <= 3'd0;
            word_valid_reg <= 1'b0;
        end else begin
            key_valid_reg  <= 1'b0;
            word_valid_reg <= 1'b0;
            if (accept) begin
                key_code_reg  <= code;
                key_valid_reg <= 1'b1;
                if (clear) begin
                    data_reg      <= {28'h0, code};
                    digit_cnt_reg <= 3'd1;
                end else begin
                    data_reg       <= {data_reg[27:0], code};
                    digit_cnt_reg  <= digit_cnt_reg + 3'd1;
                    word_valid_reg <= (digit_cnt_reg == 3'd7);
                end
            end else if (clear) begin
                data_reg      <= 32'h0;
                digit_cnt_reg <= 3'd0;
            end
        end
    end

    assign key_col    = key_col_reg;
    assign key_code   = key_code_reg;
    assign key_valid  = key_valid_reg;
    assign data       = data_reg;
    assign digit_cnt  = digit_cnt_reg;
    assign word_valid = word_valid_reg;

endmodule
